// File: rtl/dma_sched_pkg.sv
// Shared types and defaults for the DMA channel scheduler and its round-robin picker.
package dma_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_ACTIVE,
    S_YIELD,
    S_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    ST_COMPLETE = 2'b00,
    ST_YIELDED  = 2'b01,
    ST_ABORTED  = 2'b10,
    ST_TIMEOUT  = 2'b11
  } ch_status_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CH_W        = 2;
  localparam int DEF_QUANTUM     = 8;
  localparam int DEF_WDOG_CYCLES = 1024;

  // A finished transfer wins over any pending abort; an issued abort outranks a timeout.
  function automatic ch_status_e done_status(input logic complete, input logic aborted,
                                             input logic timed_out);
    if (complete) return ST_COMPLETE;
    if (aborted) return ST_ABORTED;
    if (timed_out) return ST_TIMEOUT;
    return ST_YIELDED;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational two-level picker: high-priority requesters first, then round-robin
// starting one past the previous grant.
module dma_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] hipri,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   winner,
  output logic              valid
);

  logic [NUM_CH-1:0] hi_req;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] cand_sh;
  logic              found;
  int                idx;

  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    hi_req  = req & hipri;
    cand    = (|hi_req) ? hi_req : req;
    valid   = |req;
    winner  = '0;
    found   = 1'b0;
    cand_sh = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx     = (int'(last_grant) + k) % NUM_CH;
      cand_sh = cand >> idx;
      if (!found && cand_sh[0]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_ch_sched.sv
// Channel scheduler for the shared DMA engine: arbitration, quantum yield, abort, status.
// Optional watchdog abort is built when DMA_SCHED_WDOG_EN is defined.
module dma_ch_sched
  import dma_sched_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_W        = DEF_CH_W,
  parameter int QUANTUM     = DEF_QUANTUM,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_hipri,
  input  logic [NUM_CH-1:0] ch_abort,
  input  logic              eng_handover,
  input  logic              eng_done,
  input  logic              eng_complete,
  output logic              eng_start,
  output logic [CH_W-1:0]   eng_ch,
  output logic              eng_yield,
  output logic              eng_abort,
  output logic [NUM_CH-1:0] ch_done,
  output logic [1:0]        ch_status
);

  localparam logic [7:0] QUANT_MAX = 8'(QUANTUM);

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   eng_ch_q, eng_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              eng_start_q, eng_start_d;
  logic              eng_yield_q, eng_yield_d;
  logic              eng_abort_q, eng_abort_d;
  logic              aborted_q, aborted_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [NUM_CH-1:0] ch_done_reg_q, ch_done_reg_d;
  ch_status_e        ch_status_q, ch_status_d;
  logic [7:0]        quant_q, quant_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] others;
  logic [CH_W-1:0]   pick_ch;
  logic              pick_valid;
  logic              abort_hit;
  logic              wdog_trip;
  logic              timed_out;

  // A channel that just completed stays masked for one cycle so a dropping request is not regranted.
  assign eligible  = ch_req & ~ch_done_reg_q;
  assign grant_oh  = NUM_CH'(1) << eng_ch_q;
  assign others    = eligible & ~grant_oh;
  assign abort_hit = |(ch_abort & grant_oh);

  dma_rr_pick #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_pick (
    .req       (eligible),
    .hipri     (ch_hipri),
    .last_grant(last_grant_q),
    .winner    (pick_ch),
    .valid     (pick_valid)
  );

`ifdef DMA_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              xfer_live;

  assign xfer_live = (state_q == S_ACTIVE) || (state_q == S_YIELD);
  assign wdog_trip = xfer_live && (wdog_q == WDOG_MAX);
  assign timed_out = timeout_q;

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_q == S_START) begin
      wdog_d    = '0;
      timeout_d = 1'b0;
    end else if (xfer_live) begin
      if (eng_handover) wdog_d = '0;
      else if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
      if (wdog_trip) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES == 0);
  assign wdog_trip   = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    eng_ch_d      = eng_ch_q;
    last_grant_d  = last_grant_q;
    eng_start_d   = 1'b0;
    eng_yield_d   = eng_yield_q;
    eng_abort_d   = eng_abort_q;
    aborted_d     = aborted_q;
    ch_done_d     = '0;
    ch_done_reg_d = ch_done_q;
    ch_status_d   = ch_status_q;
    quant_d       = quant_q;
    case (state_q)
      S_IDLE: if (|ch_req) state_d = S_ARB;
      S_ARB: begin
        if (pick_valid) begin
          eng_ch_d    = pick_ch;
          eng_start_d = 1'b1;
          state_d     = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        quant_d   = '0;
        aborted_d = 1'b0;
        state_d   = S_ACTIVE;
      end
      S_ACTIVE, S_YIELD: begin
        // Completion wins over a handover arriving in the same cycle.
        if (eng_done) begin
          ch_done_d   = grant_oh;
          ch_status_d = done_status(eng_complete, aborted_q, timed_out);
          eng_yield_d = 1'b0;
          eng_abort_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          if (abort_hit) begin
            aborted_d   = 1'b1;
            eng_abort_d = 1'b1;
          end
          if (wdog_trip) eng_abort_d = 1'b1;
          if (state_q == S_ACTIVE) begin
            if (eng_handover && (quant_q != QUANT_MAX)) quant_d = quant_q + 8'd1;
            if ((quant_q == QUANT_MAX) && (|others)) begin
              eng_yield_d = 1'b1;
              state_d     = S_YIELD;
            end
          end
        end
      end
      S_DONE: begin
        last_grant_d = eng_ch_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (hreset) begin
      state_q       <= S_IDLE;
      eng_ch_q      <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      eng_start_q   <= 1'b0;
      eng_yield_q   <= 1'b0;
      eng_abort_q   <= 1'b0;
      aborted_q     <= 1'b0;
      ch_done_q     <= '0;
      ch_done_reg_q <= '0;
      ch_status_q   <= ST_COMPLETE;
      quant_q       <= '0;
    end else begin
      state_q       <= state_d;
      eng_ch_q      <= eng_ch_d;
      last_grant_q  <= last_grant_d;
      eng_start_q   <= eng_start_d;
      eng_yield_q   <= eng_yield_d;
      eng_abort_q   <= eng_abort_d;
      aborted_q     <= aborted_d;
      ch_done_q     <= ch_done_d;
      ch_done_reg_q <= ch_done_reg_d;
      ch_status_q   <= ch_status_d;
      quant_q       <= quant_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_ch    = eng_ch_q;
  assign eng_yield = eng_yield_q;
  assign eng_abort = eng_abort_q;
  assign ch_done   = ch_done_q;
  assign ch_status = ch_status_q;

endmodule

// File: tb/tb_dma_ch_sched.sv
// Directed bench for dma_ch_sched: a cycle-level reference model plus literal spot checks.
module tb_dma_ch_sched;

  localparam int NUM_CH  = 4;
  localparam int QUANTUM = 2;
  localparam int WDOG    = 16;

  localparam int PH_IDLE = 0, PH_ARB = 1, PH_START = 2, PH_ACTIVE = 3, PH_YIELD = 4, PH_DONE = 5;

  logic       hclk;
  logic       hreset;
  logic [3:0] ch_req, ch_hipri, ch_abort;
  logic       eng_handover, eng_done, eng_complete;
  logic       eng_start, eng_yield, eng_abort;
  logic [1:0] eng_ch;
  logic [3:0] ch_done;
  logic [1:0] ch_status;

  int checks = 0;
  int failures = 0;

  dma_ch_sched #(
    .NUM_CH     (NUM_CH),
    .CH_W       (2),
    .QUANTUM    (QUANTUM),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .ch_req      (ch_req),
    .ch_hipri    (ch_hipri),
    .ch_abort    (ch_abort),
    .eng_handover(eng_handover),
    .eng_done    (eng_done),
    .eng_complete(eng_complete),
    .eng_start   (eng_start),
    .eng_ch      (eng_ch),
    .eng_yield   (eng_yield),
    .eng_abort   (eng_abort),
    .ch_done     (ch_done),
    .ch_status   (ch_status)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Priority-then-round-robin choice, written straight from the arbitration rule.
  function automatic int rr_pick(input logic [3:0] req, input logic [3:0] hip, input int last);
    logic [3:0] pool;
    pool = ((req & hip) != 4'b0) ? (req & hip) : req;
    for (int k = 1; k <= NUM_CH; k++) begin
      int i;
      i = (last + k) % NUM_CH;
      if (((pool >> i) & 4'd1) != 4'd0) return i;
    end
    return 0;
  endfunction

  int         ph, m_ch, m_last, m_hand, m_wd;
  logic       m_start, m_yield, m_abort, m_chab, m_tmo;
  logic [3:0] m_done, m_mask;
  logic [1:0] m_status;

  always @(posedge hclk or posedge hreset) begin : model
    logic [3:0] mask_now, elig;
    int hand_old, wd_old;
    if (hreset) begin
      ph = PH_IDLE; m_ch = 0; m_last = NUM_CH - 1; m_hand = 0; m_wd = 0;
      m_start = 0; m_yield = 0; m_abort = 0; m_chab = 0; m_tmo = 0;
      m_done = 0; m_mask = 0; m_status = 0;
    end else begin
      mask_now = m_mask;
      m_mask   = m_done;
      m_start  = 0;
      m_done   = 0;
      elig     = ch_req & ~mask_now;
      case (ph)
        PH_IDLE: if (ch_req != 4'b0) ph = PH_ARB;
        PH_ARB: begin
          if (elig == 4'b0) ph = PH_IDLE;
          else begin
            m_ch = rr_pick(elig, ch_hipri, m_last);
            m_start = 1;
            ph = PH_START;
          end
        end
        PH_START: begin
          m_hand = 0; m_wd = 0; m_chab = 0; m_tmo = 0;
          ph = PH_ACTIVE;
        end
        PH_ACTIVE, PH_YIELD: begin
          if (eng_done) begin
            m_done   = 4'b1 << m_ch;
            m_status = eng_complete ? 2'b00 : m_chab ? 2'b10 : m_tmo ? 2'b11 : 2'b01;
            m_yield  = 0;
            m_abort  = 0;
            ph = PH_DONE;
          end else begin
            hand_old = m_hand;
            wd_old   = m_wd;
            if (((ch_abort >> m_ch) & 4'd1) != 4'd0) begin
              m_chab = 1;
              m_abort = 1;
            end
`ifdef DMA_SCHED_WDOG_EN
            if (eng_handover) m_wd = 0;
            else if (m_wd < WDOG) m_wd++;
            if (wd_old == WDOG) begin
              m_tmo = 1;
              m_abort = 1;
            end
`endif
            if (ph == PH_ACTIVE) begin
              if (eng_handover && m_hand < QUANTUM) m_hand++;
              if (hand_old == QUANTUM && (elig & ~(4'b1 << m_ch)) != 4'b0) begin
                m_yield = 1;
                ph = PH_YIELD;
              end
            end
          end
        end
        PH_DONE: begin
          m_last = m_ch;
          ph = PH_IDLE;
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  always @(negedge hclk) begin
    check("cmp_eng_start", eng_start, m_start);
    check("cmp_eng_ch", eng_ch, m_ch);
    check("cmp_eng_yield", eng_yield, m_yield);
    check("cmp_eng_abort", eng_abort, m_abort);
    check("cmp_ch_done", ch_done, m_done);
    if (m_done != 4'b0) check("cmp_ch_status", ch_status, m_status);
  end

  task automatic wait_sig(input string name, input int sel, input int max_cyc);
    logic hit;
    hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge hclk);
      case (sel)
        0: hit = eng_start;
        1: hit = eng_yield;
        default: hit = eng_abort;
      endcase
    end
    check(name, hit, 1);
  endtask

  task automatic finish_xfer(input string name, input logic complete, input logic [1:0] exp_st,
                             input logic [3:0] exp_done, input logic [3:0] new_req);
    eng_done = 1; eng_complete = complete; ch_abort = 0;
    @(negedge hclk);
    eng_done = 0; eng_complete = 0;
    check({name, "_done"}, ch_done, exp_done);
    check({name, "_status"}, ch_status, exp_st);
    ch_req = new_req;
  endtask

  task automatic pulse_handover();
    eng_handover = 1;
    @(negedge hclk);
    eng_handover = 0;
    @(negedge hclk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    hreset = 0; ch_req = 0; ch_hipri = 0; ch_abort = 0;
    eng_handover = 0; eng_done = 0; eng_complete = 0;
    #1 hreset = 1;
    @(negedge hclk);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_ch", eng_ch, 0);
    check("rst_ch_done", ch_done, 0);
    check("rst_abort_yield", {eng_abort, eng_yield}, 0);
    @(negedge hclk);
    hreset = 0;

    // Arbitration and latency: ch0 then ch2
    ch_req = 4'b0101;
    @(negedge hclk);
    check("lat_cycle1_no_start", eng_start, 0);
    @(negedge hclk);
    check("lat_cycle2_start", eng_start, 1);
    check("lat_first_ch", eng_ch, 0);
    @(negedge hclk);
    finish_xfer("t1_ch0", 1, 2'b00, 4'b0001, 4'b0100);
    wait_sig("t1_start_ch2", 0, 8);
    check("t1_ch2", eng_ch, 2);
    @(negedge hclk);
    finish_xfer("t1_ch2", 1, 2'b00, 4'b0100, 4'b0000);

    // Priority: ch3 (hipri), then ch0, then ch1
    ch_req = 4'b1011; ch_hipri = 4'b1000;
    wait_sig("t2_start_a", 0, 8);
    check("t2_hipri_ch3", eng_ch, 3);
    @(negedge hclk);
    finish_xfer("t2_ch3", 1, 2'b00, 4'b1000, 4'b0011);
    wait_sig("t2_start_b", 0, 8);
    check("t2_rr_ch0", eng_ch, 0);
    @(negedge hclk);
    finish_xfer("t2_ch0", 1, 2'b00, 4'b0001, 4'b0010);
    wait_sig("t2_start_c", 0, 8);
    check("t2_rr_ch1", eng_ch, 1);
    @(negedge hclk);
    finish_xfer("t2_ch1", 1, 2'b00, 4'b0010, 4'b0000);
    ch_hipri = 0;

    // Quantum yield: ch0 yields to ch1 and is regranted afterwards
    ch_req = 4'b0011;
    wait_sig("t3_start_a", 0, 8);
    check("t3_ch0", eng_ch, 0);
    @(negedge hclk);
    pulse_handover();
    check("t3_no_yield_after_1", eng_yield, 0);
    pulse_handover();
    wait_sig("t3_yield", 1, 3);
    finish_xfer("t3_ch0_yield", 0, 2'b01, 4'b0001, 4'b0011);
    wait_sig("t3_start_b", 0, 8);
    check("t3_ch1", eng_ch, 1);
    @(negedge hclk);
    finish_xfer("t3_ch1", 1, 2'b00, 4'b0010, 4'b0001);
    wait_sig("t3_start_c", 0, 8);
    check("t3_ch0_again", eng_ch, 0);
    @(negedge hclk);
    finish_xfer("t3_ch0_end", 1, 2'b00, 4'b0001, 4'b0000);

    // Abort: status 10 when stopped early, 00 when the transfer still completed
    ch_req = 4'b0001;
    wait_sig("t4_start_a", 0, 8);
    @(negedge hclk);
    ch_abort = 4'b0001;
    @(negedge hclk);
    check("t4_abort_next_cycle", eng_abort, 1);
    finish_xfer("t4_aborted", 0, 2'b10, 4'b0001, 4'b0001);
    check("t4_abort_cleared", eng_abort, 0);
    wait_sig("t4_start_b", 0, 8);
    @(negedge hclk);
    ch_abort = 4'b0001;
    @(negedge hclk);
    check("t4_abort_again", eng_abort, 1);
    finish_xfer("t4_complete_wins", 1, 2'b00, 4'b0001, 4'b0000);

    // Reset during YIELD
    ch_req = 4'b0011;
    wait_sig("t5_start", 0, 8);
    check("t5_ch1", eng_ch, 1);
    @(negedge hclk);
    pulse_handover();
    pulse_handover();
    wait_sig("t5_yield", 1, 3);
    #2 hreset = 1; ch_req = 0;
    #1;
    check("t5_rst_start", eng_start, 0);
    check("t5_rst_ch", eng_ch, 0);
    check("t5_rst_yield", eng_yield, 0);
    check("t5_rst_abort", eng_abort, 0);
    check("t5_rst_done", ch_done, 0);
    check("t5_rst_status", ch_status, 0);
    @(negedge hclk);
    hreset = 0;
    ch_req = 4'b0010;
    @(negedge hclk);
    check("t5_c1_no_start", eng_start, 0);
    @(negedge hclk);
    check("t5_c2_start", eng_start, 1);
    check("t5_c2_ch1", eng_ch, 1);
    @(negedge hclk);
    finish_xfer("t5_ch1", 1, 2'b00, 4'b0010, 4'b0000);

`ifdef DMA_SCHED_WDOG_EN
    // Watchdog: no handovers, abort fires and status reports timeout
    ch_req = 4'b0001;
    wait_sig("t6_start", 0, 8);
    check("t6_ch0", eng_ch, 0);
    wait_sig("t6_wdog_abort", 2, 30);
    finish_xfer("t6_timeout", 0, 2'b11, 4'b0001, 4'b0000);
`endif

    repeat (4) @(negedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
